// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one single-ported memory shared by the fetch (IF) and data (MEM) ports, data first.
// Define MEM_ARB_STARVE_EN to force a fetch grant after STARVE_LIM consecutive fetch losses.
module mem_port_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int LAT = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_ready_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_ready_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o
);
  localparam int CW = $clog2(LAT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dsel_q, dsel_d, we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, if_rdata_q, d_rdata_q;
  logic mem_en_q, mem_we_q, if_ready_q, d_ready_q, busy_q;
  logic force_f, grant_d, grant_f, capture;
  assign grant_d = d_req_i && !force_f;
  assign grant_f = if_req_i && !grant_d;
  assign capture = state_q == WAIT && cnt_q == CW'(1) && !we_q;
`ifdef MEM_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIM + 1);
  logic [SW-1:0] starve_q, starve_d;
  assign force_f = if_req_i && starve_q == SW'(STARVE_LIM);
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE)
      starve_d = grant_f ? '0 :
                 (grant_d && if_req_i && starve_q != SW'(STARVE_LIM)) ? starve_q + SW'(1) : starve_q;
  end
  always_ff @(posedge clock_i) begin
    if (!reset_i) starve_q <= '0;
    else starve_q <= starve_d;
  end
`else
  logic unused_starve_lim;
  assign unused_starve_lim = |STARVE_LIM;
  assign force_f = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dsel_d = dsel_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (grant_d || grant_f) begin
        state_d = ISSUE;
        dsel_d = grant_d;
        we_d = grant_d && d_we_i;
        addr_d = grant_d ? d_addr_i : if_addr_i;
        wdata_d = d_wdata_i;
      end
      ISSUE: begin
        cnt_d = CW'(LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        state_d = cnt_q == CW'(1) ? DONE : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from next state so they line up with the state they describe.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dsel_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      if_rdata_q <= '0;
      d_rdata_q <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      if_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dsel_q <= dsel_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      if (capture && dsel_q) d_rdata_q <= mem_rdata_i;
      if (capture && !dsel_q) if_rdata_q <= mem_rdata_i;
      mem_en_q <= state_d == ISSUE;
      mem_we_q <= state_d == ISSUE && we_d;
      if_ready_q <= state_d == DONE && !dsel_d;
      d_ready_q <= state_d == DONE && dsel_d;
      busy_q <= state_d != IDLE;
    end
  end
  assign if_rdata_o = if_rdata_q;
  assign if_ready_o = if_ready_q;
  assign d_rdata_o = d_rdata_q;
  assign d_ready_o = d_ready_q;
  assign mem_en_o = mem_en_q;
  assign mem_we_o = mem_we_q;
  assign mem_addr_o = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random and directed traffic against a cycle-scheduled transaction model.
// Honours MEM_ARB_STARVE_EN the same way the design does.
module tb_mem_port_arbiter;
  localparam int LAT = 3;
  localparam int LIM = 4;
  typedef struct { logic [9:0] a; logic we; logic [31:0] wd; } req_t;
  logic clk = 1'b0, reset = 1'b0, mem_init = 1'b0;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [9:0] if_addr = '0, d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic if_ready, d_ready, mem_en, mem_we, busy;
  logic [9:0] mem_addr;
  logic [31:0] mem [1024];
  logic [31:0] pipe [LAT];
  logic [31:0] ref_mem [1024];
  int n_checks = 0, n_fail = 0, cyc = 0;
  bit act = 0, dsel = 0, we = 0;
  int t0 = 0, free = 0, starve = 0;
  logic [9:0] a;
  logic [31:0] wd, rd_exp, last_if, last_d;
  req_t dq[$], fq[$];
  bit gseq[$];
  int last_d_idx, f_before;
  always #5 clk = ~clk;
  mem_port_arbiter #(.AW(10), .DW(32), .LAT(LAT), .STARVE_LIM(LIM)) dut (
    .clock_i(clk), .reset_i(reset),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ready_o(if_ready),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_rdata_o(d_rdata), .d_ready_o(d_ready),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .busy_o(busy)
  );
  function automatic logic [31:0] init_val(input int i);
    return i == 5 ? 32'h2002000A : i == 9 ? 32'h55 : i == 7 ? 32'h1234 : 32'h9E3779B9 * (i + 1);
  endfunction
  // Memory with LAT-cycle read latency measured from the edge that samples mem_en.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      pipe[0] <= mem[mem_addr];
    end
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic req_t mk(input logic [9:0] ad, input logic w, input logic [31:0] dat);
    req_t r;
    r.a = ad;
    r.we = w;
    r.wd = dat;
    return r;
  endfunction
  task automatic do_reset();
    reset = 1'b0;
    if_req = 1'b0;
    d_req = 1'b0;
    act = 0;
    @(posedge clk); #1; cyc++;
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_if_ready", if_ready, 0);
    check("rst_d_ready", d_ready, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    last_if = '0;
    last_d = '0;
    starve = 0;
    free = 0;
    reset = 1'b1;
  endtask
  task automatic step();
    bit en_e, rdy, gd;
    req_t r;
    @(posedge clk); #1; cyc++;
    en_e = act && cyc == t0 + 1;
    rdy = act && cyc == t0 + LAT + 2;
    if (rdy && !we && dsel) last_d = rd_exp;
    if (rdy && !we && !dsel) last_if = rd_exp;
    check("busy", busy, act && cyc > t0);
    check("mem_en", mem_en, en_e);
    if (en_e) begin
      check("mem_addr", mem_addr, a);
      check("mem_we", mem_we, we);
      if (we) check("mem_wdata", mem_wdata, wd);
    end
    check("if_ready", if_ready, rdy && !dsel);
    check("d_ready", d_ready, rdy && dsel);
    check("if_rdata", if_rdata, last_if);
    check("d_rdata", d_rdata, last_d);
    if (rdy) begin
      act = 0;
      if (dsel) d_req = 1'b0;
      else if_req = 1'b0;
    end
    if (!d_req && dq.size() > 0 && !(act && dsel)) begin
      r = dq.pop_front();
      d_req = 1'b1;
      d_addr = r.a;
      d_we = r.we;
      d_wdata = r.wd;
    end
    if (!if_req && fq.size() > 0 && !(act && !dsel)) begin
      r = fq.pop_front();
      if_req = 1'b1;
      if_addr = r.a;
    end
    if (cyc >= free) begin
      gd = d_req;
`ifdef MEM_ARB_STARVE_EN
      if (if_req && starve == LIM) gd = 0;
`endif
      if (gd || if_req) begin
        act = 1;
        t0 = cyc;
        free = cyc + LAT + 3;
        dsel = gd;
        a = gd ? d_addr : if_addr;
        we = gd && d_we;
        wd = d_wdata;
        if (we) ref_mem[a] = wd;
        else rd_exp = ref_mem[a];
        gseq.push_back(gd);
`ifdef MEM_ARB_STARVE_EN
        starve = !gd ? 0 : (if_req && starve < LIM) ? starve + 1 : starve;
`endif
      end
    end
  endtask
  task automatic run_idle(input int budget);
    int k = 0;
    while ((dq.size() > 0 || fq.size() > 0 || if_req || d_req || cyc < free) && k < budget) begin
      step();
      k++;
    end
    check("drain_in_budget", k < budget, 1);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected finish before 300000");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    mem_init = 1'b1;
    do_reset();
    mem_init = 1'b0;
    fq.push_back(mk(10'd5, 0, 0));
    run_idle(50);
    fq.push_back(mk(10'd2, 0, 0));
    dq.push_back(mk(10'd9, 0, 0));
    run_idle(50);
    dq.push_back(mk(10'd3, 1, 32'hDEADBEEF));
    run_idle(50);
    fq.push_back(mk(10'd3, 0, 0));
    run_idle(50);
    dq.push_back(mk(10'd7, 0, 0));
    run_idle(50);
    dq.push_back(mk(10'd9, 0, 0));
    for (int k = 0; k < 20 && !(act && cyc == t0 + 2); k++) step();
    check("reached_wait", act && cyc == t0 + 2, 1);
    do_reset();
    dq.push_back(mk(10'd7, 0, 0));
    run_idle(50);
    gseq.delete();
    for (int i = 0; i < 15; i++) begin
      dq.push_back(mk(10'(i), 0, 0));
      fq.push_back(mk(10'(i + 100), 0, 0));
    end
    run_idle(400);
    last_d_idx = -1;
    f_before = 0;
    foreach (gseq[i]) if (gseq[i]) last_d_idx = i;
    foreach (gseq[i]) if (!gseq[i] && i < last_d_idx) f_before++;
    check("contention_first_is_d", gseq[0], 1);
`ifdef MEM_ARB_STARVE_EN
    check("contention_forced_fetches", f_before, (15 - 1) / LIM);
`else
    check("contention_forced_fetches", f_before, 0);
`endif
    repeat (400) begin
      if (dq.size() == 0 && $urandom_range(2) == 0)
        dq.push_back(mk(10'($urandom_range(15)), 1'($urandom_range(1)), $urandom));
      if (fq.size() == 0 && $urandom_range(2) == 0)
        fq.push_back(mk(10'($urandom_range(15)), 0, 0));
      step();
      if (act && cyc > t0 && $urandom_range(15) == 0) begin
        if (dsel) d_req = 1'b0;
        else if_req = 1'b0;
      end
    end
    run_idle(500);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported word memory between the IF-stage fetch port and the MEM-stage load/store port of the 5-stage pipeline.
- Replaces the separate instruction and data memory instances with one shared memory plus this arbiter.
- Serialises accesses, sequences the memory's fixed read latency, and returns one-cycle ready pulses. The pipeline uses these pulses to derive its PC/IFID/EXMEM stalls.
- Data port has priority, because it holds the older instruction.

Parameters:
- AW, 10, word-address width.
- DW, 32, data width.
- LAT, 1, memory read latency in cycles (≥1). Data is valid LAT cycles after mem_en is sampled.
- STARVE_LIM, 4, consecutive fetch losses before a forced fetch grant. Used only with MEM_ARB_STARVE_EN.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  AW  fetch word address
- if_rdata  out  DW  fetched instruction; valid while if_ready=1, held otherwise
- if_ready  out  1  one-cycle completion pulse, fetch port
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data word address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data; valid while d_ready=1
- d_ready  out  1  one-cycle completion pulse, data port
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- busy  out  1  high whenever state ≠ IDLE

Behaviour:
- All outputs are registered.
- Reset (reset=0 at a clock edge):
  - state goes to IDLE.
  - mem_en, mem_we, if_ready, d_ready, busy = 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata = 0.
  - Latency counter and starvation counter = 0.
  - A reset mid-transaction discards any in-flight response; no ready pulse follows.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If d_req=1, grant D; else if if_req=1, grant F; else stay in IDLE.
  - On grant, latch the owner, address, we (0 for F) and wdata. Next state is ISSUE.
  - Simultaneous requests: D wins; the fetch request stays pending.
- ISSUE:
  - mem_en=1 for exactly this one cycle; mem_we, mem_addr and mem_wdata come from the latched values.
  - Load cnt=LAT, then go to WAIT.
- WAIT:
  - cnt decrements each cycle.
  - On the edge where cnt==1, capture mem_rdata into the owner's rdata register, then go to DONE.
  - Stores also wait LAT cycles; d_rdata is not updated on a store.
- DONE:
  - The owner's ready=1 for exactly this cycle.
  - No arbitration occurs in DONE; next state is IDLE.
  - A requester that sees ready must drop req or present a new request. A request seen in IDLE is always a new transaction.
- Timing: a request sampled in IDLE in cycle t produces ready in cycle t+LAT+2. Peak throughput is one access per LAT+3 cycles.
- Request dropped mid-transaction: the access completes and ready still pulses; the requester ignores it.
- if_rdata and d_rdata hold their last captured value outside ready.
- Addresses pass through unmodified; there is no wrap or overflow handling at this level.

Optional Feature:
- Macro: MEM_ARB_STARVE_EN.
- With the macro defined:
  - A saturating counter increments on each IDLE decision where if_req=1 and D is granted.
  - When the counter equals STARVE_LIM, the next IDLE decision with if_req=1 grants F even if d_req=1.
  - The counter clears on any F grant and on reset.
- Without the macro: strict D priority; the counter logic is absent and STARVE_LIM is unused.

Test Plan:
- LAT=1, fetch only: cycle 0 if_req=1, if_addr=5, mem[5]=0x2002000A -> mem_en=1 with mem_addr=5 in cycle 1; if_ready=1 with if_rdata=0x2002000A in cycle 3; busy is 1 for cycles 1-3.
- Simultaneous requests: if_req=1 (addr 2) and d_req=1 (load, addr 9, mem[9]=0x55) in cycle 0 -> d_ready with 0x55 in cycle 3; fetch issued in cycle 5 (mem_addr=2); if_ready in cycle 7.
- Store: d_we=1, d_addr=3, d_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF in cycle 1; d_ready in cycle 3; d_rdata unchanged. A later fetch of addr 3 returns 0xDEADBEEF.
- LAT=3, load of addr 7 = 0x1234 -> d_ready in cycle 5 with 0x1234; no ready pulse in cycles 1-4.
- Reset asserted in WAIT -> next cycle IDLE, all outputs 0, no ready pulse. A request after reset is serviced normally.
- MEM_ARB_STARVE_EN, STARVE_LIM=4, d_req and if_req held high continuously -> 4 D grants, then 1 F grant, repeating. Without the macro, F is never granted.
